direction_input_ctrl: RTL and testbench

//  Upstream of the Pacman controller: turns four raw player buttons into its 2-bit direction input.

---
 rtl/pacman_pkg.sv | 35 +++
 rtl/button_debouncer.sv | 73 +++++++
 rtl/direction_input_ctrl.sv | 115 +++++++++++
 tb/tb_direction_input_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pacman definitions: direction encoding, the frame update line,
// and the button-press priority encoder used by the input controller.
package pacman_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Vertical scan line on which Pacman, the ghosts and the input controller update
  localparam logic [9:0] FRAME_LINE = 10'd480;

  // A decoded press: valid when at least one button rose this cycle
  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
  } press_t;

  // Press priority: up > left > down > right. Bit 0=up, 1=left, 2=down, 3=right.
  function automatic press_t encode_press(input logic [3:0] rise);
    press_t p;
    p.valid = |rise;
    if (rise[0]) begin
      p.dir = DIR_UP;
    end else if (rise[1]) begin
      p.dir = DIR_LEFT;
    end else if (rise[2]) begin
      p.dir = DIR_DOWN;
    end else begin
      p.dir = DIR_RIGHT;
    end
    return p;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw, asynchronous, active-high button: 2-FF synchroniser followed by a
// counting debouncer. 'level' is the accepted button level; 'rise' pulses for
// one cycle when the accepted level goes from 0 to 1.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd125000,
  parameter int unsigned CNT_W           = 32'd17
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  // Counter value on the last mismatching cycle before the new level is accepted
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync_meta_r;
  logic             sync_r;
  logic             level_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;

  logic             level_s;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_s;

  // Two-flop synchroniser bringing the raw button into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= raw;
      sync_r      <= sync_meta_r;
    end
  end

  // Debounce decision: count consecutive mismatching cycles, accept on the last one
  always_comb begin
    cnt_s   = cnt_r;
    level_s = level_r;
    rise_s  = 1'b0;
    if (sync_r == level_r) begin
      cnt_s = CNT_ZERO;
    end else if (cnt_r == LAST_CNT) begin
      level_s = sync_r;
      cnt_s   = CNT_ZERO;
      rise_s  = sync_r;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state and registered press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      level_r <= level_s;
      rise_r  <= rise_s;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/direction_input_ctrl.sv
// Turns four raw player buttons into Pacman's 2-bit direction input.
// The most recent debounced press is queued as a pending turn and applied
// only on the frame strobe, so Pacman sees one direction for a whole frame.
module direction_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd125000,
  parameter int unsigned CNT_W           = 32'd17,
  parameter logic [9:0]  FRAME_LINE      = pacman_pkg::FRAME_LINE,
  parameter logic [1:0]  RESET_DIR       = pacman_pkg::DIR_RIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_left,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic [9:0] svpos,
  output logic [1:0] direction,
  output logic       dir_changed,
  output logic       pending
);

  import pacman_pkg::*;

  logic [3:0] rise_s;
  logic [3:0] btn_level_unused_s;
  press_t     press_s;
  logic       strobe_s;

  logic [9:0] svpos_q_r;
  logic [1:0] direction_r;
  logic [1:0] pend_dir_r;
  logic       pending_r;
  logic       dir_changed_r;

  logic [1:0] direction_s;
  logic [1:0] pend_dir_s;
  logic       pending_s;
  logic       dir_changed_s;
  logic [1:0] apply_dir_s;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up),
    .level(btn_level_unused_s[0]), .rise(rise_s[0])
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clk(clk), .reset(reset), .raw(btn_left),
    .level(btn_level_unused_s[1]), .rise(rise_s[1])
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
    .clk(clk), .reset(reset), .raw(btn_down),
    .level(btn_level_unused_s[2]), .rise(rise_s[2])
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clk(clk), .reset(reset), .raw(btn_right),
    .level(btn_level_unused_s[3]), .rise(rise_s[3])
  );

  // Highest-priority press this cycle
  assign press_s = encode_press(rise_s);

  // Strobe on entry to the frame line only; svpos stays there for a whole line
  assign strobe_s = (svpos == FRAME_LINE) && (svpos_q_r != FRAME_LINE);

  // Turn queueing and frame-aligned application
  always_comb begin
    direction_s   = direction_r;
    pend_dir_s    = pend_dir_r;
    pending_s     = pending_r;
    dir_changed_s = 1'b0;
    apply_dir_s   = direction_r;
    if (strobe_s) begin
      // A press landing on the strobe is newer than anything queued
      if (press_s.valid) begin
        apply_dir_s = press_s.dir;
      end else if (pending_r) begin
        apply_dir_s = pend_dir_r;
      end else begin
        apply_dir_s = direction_r;
      end
      direction_s   = apply_dir_s;
      dir_changed_s = (apply_dir_s != direction_r);
      pending_s     = 1'b0;
    end else if (press_s.valid) begin
      pend_dir_s = press_s.dir;
      pending_s  = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  // Controller state; svpos_q clears so a reset held through line 480 still strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      svpos_q_r     <= 10'd0;
      direction_r   <= RESET_DIR;
      pend_dir_r    <= 2'd0;
      pending_r     <= 1'b0;
      dir_changed_r <= 1'b0;
    end else begin
      svpos_q_r     <= svpos;
      direction_r   <= direction_s;
      pend_dir_r    <= pend_dir_s;
      pending_r     <= pending_s;
      dir_changed_r <= dir_changed_s;
    end
  end

  assign direction   = direction_r;
  assign pending     = pending_r;
  assign dir_changed = dir_changed_r;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Self-checking bench for direction_input_ctrl with a short debounce window.
// A behavioural model (sample windows per button, frame rules) predicts the outputs.
module tb_direction_input_ctrl;

  localparam int DB = 4;
  localparam int CW = 3;
  localparam int HL = DB + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_left = 1'b0, btn_down = 1'b0, btn_right = 1'b0;
  logic [9:0] svpos = 10'd480;
  logic [1:0] direction;
  logic       dir_changed;
  logic       pending;

  int vectors = 0;
  int errors  = 0;

  // Model state
  bit         hist [4][HL];   // hist[b][k] = button b sampled k edges ago
  bit         stbl [4];
  bit         rse  [4];
  logic [1:0] m_dir  = 2'd3;
  bit         m_pend = 1'b0;
  logic [1:0] m_pdir = 2'd0;
  bit         m_chg  = 1'b0;
  int         m_svq  = 0;

  direction_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down), .btn_right(btn_right),
    .svpos(svpos), .direction(direction), .dir_changed(dir_changed), .pending(pending)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit b [4];
    bit strobe, pv, all_diff;
    logic [1:0] pd, nd;
    b[0] = btn_up; b[1] = btn_left; b[2] = btn_down; b[3] = btn_right;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < HL; k++) hist[i][k] = 1'b0;
        stbl[i] = 1'b0;
        rse[i]  = 1'b0;
      end
      m_dir = 2'd3; m_pend = 1'b0; m_pdir = 2'd0; m_chg = 1'b0; m_svq = 0;
      return;
    end
    // Controller: uses press pulses produced by the previous edge
    strobe = (svpos == 10'd480) && (m_svq != 480);
    pv = 1'b0; pd = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rse[i]) begin pv = 1'b1; pd = 2'(i); end
    end
    if (strobe) begin
      nd = pv ? pd : (m_pend ? m_pdir : m_dir);
      m_chg  = (nd != m_dir);
      m_dir  = nd;
      m_pend = 1'b0;
    end else begin
      m_chg = 1'b0;
      if (pv) begin m_pdir = pd; m_pend = 1'b1; end
    end
    m_svq = int'(svpos);
    // Button accepted once DB consecutive synchronised samples disagree with it
    for (int i = 0; i < 4; i++) begin
      for (int k = HL - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = b[i];
      all_diff = 1'b1;
      for (int k = 2; k < HL; k++) if (hist[i][k] == stbl[i]) all_diff = 1'b0;
      rse[i] = 1'b0;
      if (all_diff) begin
        stbl[i] = ~stbl[i];
        rse[i]  = stbl[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; svpos = 10'd480;
    repeat (3) tick();
    vectors += 3;
    if (direction !== 2'd3) begin errors++; $display("FAIL reset_dir got %0d want 3", direction); end
    if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b want 0", pending); end
    if (dir_changed !== 1'b0) begin errors++; $display("FAIL reset_chg got %0b want 0", dir_changed); end
    reset = 1'b0;
    tick();
    vectors += 2;
    if (direction !== 2'd3) begin errors++; $display("FAIL post_reset_strobe_dir got %0d want 3", direction); end
    if (dir_changed !== 1'b0) begin errors++; $display("FAIL post_reset_strobe_chg got %0b want 0", dir_changed); end
  endtask

  task automatic test_glitch();
    svpos = 10'd100;
    btn_up = 1'b1; tick(); tick();
    btn_up = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      vectors++;
      if (pending !== 1'b0) begin errors++; $display("FAIL glitch_pending cyc %0d got %0b want 0", c, pending); end
    end
    svpos = 10'd480; tick();
    vectors += 2;
    if (direction !== 2'd3) begin errors++; $display("FAIL glitch_dir got %0d want 3", direction); end
    if (dir_changed !== 1'b0) begin errors++; $display("FAIL glitch_chg got %0b want 0", dir_changed); end
  endtask

  task automatic test_hold();
    svpos = 10'd100;
    btn_left = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors += 2;
      if (pending !== m_pend) begin errors++; $display("FAIL hold_pending cyc %0d got %0b want %0b", c, pending, m_pend); end
      if (direction !== 2'd3) begin errors++; $display("FAIL hold_dir cyc %0d got %0d want 3", c, direction); end
    end
    btn_left = 1'b0;
    vectors++;
    if (pending !== 1'b1) begin errors++; $display("FAIL hold_pending_end got %0b want 1", pending); end
    svpos = 10'd480; tick();
    vectors += 3;
    if (direction !== 2'd1) begin errors++; $display("FAIL hold_apply_dir got %0d want 1", direction); end
    if (pending !== 1'b0) begin errors++; $display("FAIL hold_apply_pending got %0b want 0", pending); end
    if (dir_changed !== 1'b1) begin errors++; $display("FAIL hold_chg_pulse got %0b want 1", dir_changed); end
    tick();
    vectors += 2;
    if (dir_changed !== 1'b0) begin errors++; $display("FAIL hold_chg_one_cycle got %0b want 0", dir_changed); end
    if (direction !== 2'd1) begin errors++; $display("FAIL hold_dir_kept got %0d want 1", direction); end
  endtask

  task automatic test_simultaneous();
    svpos = 10'd100;
    btn_down = 1'b1; btn_right = 1'b1;
    repeat (8) tick();
    btn_down = 1'b0; btn_right = 1'b0;
    repeat (8) tick();
    vectors++;
    if (pending !== 1'b1) begin errors++; $display("FAIL simul_pending got %0b want 1", pending); end
    svpos = 10'd480; tick();
    vectors += 3;
    if (direction !== 2'd2) begin errors++; $display("FAIL simul_dir got %0d want 2", direction); end
    if (pending !== 1'b0) begin errors++; $display("FAIL simul_pending_after got %0b want 0", pending); end
    if (dir_changed !== 1'b1) begin errors++; $display("FAIL simul_chg got %0b want 1", dir_changed); end
  endtask

  task automatic test_latest_press();
    logic [1:0] prev;
    bit exp_chg;
    prev = m_dir;
    svpos = 10'd100;
    btn_up = 1'b1; repeat (8) tick();
    btn_up = 1'b0; repeat (8) tick();
    btn_right = 1'b1; repeat (8) tick();
    btn_right = 1'b0; repeat (8) tick();
    svpos = 10'd480; tick();
    exp_chg = (prev != 2'd3);
    vectors += 2;
    if (direction !== 2'd3) begin errors++; $display("FAIL latest_dir got %0d want 3", direction); end
    if (dir_changed !== exp_chg) begin errors++; $display("FAIL latest_chg got %0b want %0b", dir_changed, exp_chg); end
  endtask

  task automatic test_long_line();
    svpos = 10'd100; repeat (2) tick();
    svpos = 10'd480;
    for (int c = 0; c < 800; c++) begin
      btn_down = (c >= 100 && c < 110);
      tick();
      vectors += 2;
      if (direction !== 2'd3) begin errors++; $display("FAIL line_dir cyc %0d got %0d want 3", c, direction); end
      if (dir_changed !== 1'b0) begin errors++; $display("FAIL line_chg cyc %0d got %0b want 0", c, dir_changed); end
    end
    vectors++;
    if (pending !== 1'b1) begin errors++; $display("FAIL line_pending got %0b want 1", pending); end
    svpos = 10'd0; repeat (2) tick();
    svpos = 10'd480; tick();
    vectors += 2;
    if (direction !== 2'd2) begin errors++; $display("FAIL next_frame_dir got %0d want 2", direction); end
    if (dir_changed !== 1'b1) begin errors++; $display("FAIL next_frame_chg got %0b want 1", dir_changed); end
  endtask

  task automatic test_random();
    logic [9:0] lines [6];
    lines[0] = 10'd100; lines[1] = 10'd479; lines[2] = 10'd480;
    lines[3] = 10'd480; lines[4] = 10'd480; lines[5] = 10'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) btn_up    = ~btn_up;
      if ($urandom_range(0, 15) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 15) == 0) btn_down  = ~btn_down;
      if ($urandom_range(0, 15) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 19) == 0) svpos = lines[$urandom_range(0, 5)];
      reset = ($urandom_range(0, 499) == 0);
      tick();
      vectors += 3;
      if (direction !== m_dir) begin errors++; $display("FAIL rand_dir cyc %0d got %0d want %0d", c, direction, m_dir); end
      if (pending !== m_pend) begin errors++; $display("FAIL rand_pending cyc %0d got %0b want %0b", c, pending, m_pend); end
      if (dir_changed !== m_chg) begin errors++; $display("FAIL rand_chg cyc %0d got %0b want %0b", c, dir_changed, m_chg); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold();
    test_simultaneous();
    test_latest_press();
    test_long_line();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
